// File: rtl/jmp_dispatch.sv
// +--------------------------------------------------------------------------+
// | Module      : jmp_dispatch                                               |
// | Description : Jump-result dispatcher. Round-robin arbitration between    |
// |               two Jump-stage requesters. Local jumps become a one-cycle  |
// |               PC load pulse. Remote/memory-write packets are queued in a |
// |               FIFO and drained over a req/ack link.                      |
// | Options     : define JDS_GATE_EN to enable the gate (drain barrier)      |
// |               instruction.                                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module jmp_dispatch #(
   parameter int DEPTH = 4
) (
   input  logic        clk_i_jds,
   input  logic        rst_i_jds,
   input  logic        vld0_i_jds,
   input  logic        vld1_i_jds,
   input  logic [23:0] req0_i_jds,
   input  logic [23:0] req1_i_jds,
   output logic        rdy0_o_jds,
   output logic        rdy1_o_jds,
   output logic        pkt_req_o_jds,
   input  logic        pkt_ack_i_jds,
   output logic [21:0] pkt_o_jds,
   output logic        pc_ld_o_jds,
   output logic [16:0] pc_dst_o_jds,
   output logic        gate_done_o_jds,
   output logic        busy_o_jds
);

   localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW     = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   // FIFO storage and bookkeeping
   logic [21:0]   fifo_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          prio_q, prio_d;
   logic          pc_ld_q, pc_ld_d;
   logic [16:0]   pc_dst_q, pc_dst_d;

   // Request classification
   logic w_gate0, w_gate1;
   logic w_rem0, w_rem1;
   logic w_loc0, w_loc1;
   logic w_run;
   logic w_full, w_nempty;
   logic w_elig0, w_elig1;
   logic w_gnt0, w_gnt1;
   logic w_push, w_pop;
   logic w_gnt_gate;
   logic [21:0] w_push_pkt;

`ifdef JDS_GATE_EN
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_GATE = 1'b1
   } state_t;

   state_t state_q;
   logic   gate_done_q;

   assign w_gate0 = req0_i_jds[23];
   assign w_gate1 = req1_i_jds[23];
   assign w_run   = (state_q == ST_RUN);

   // Barrier FSM: hold off all grants until the FIFO has fully drained
   always_ff @(posedge clk_i_jds) begin
      if (rst_i_jds) begin
         state_q     <= ST_RUN;
         gate_done_q <= 1'b0;
      end else begin
         gate_done_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (w_gnt_gate) state_q <= ST_GATE;
            end
            ST_GATE: begin
               if (!w_nempty) begin
                  state_q     <= ST_RUN;
                  gate_done_q <= 1'b1;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign gate_done_o_jds = gate_done_q;
`else
   // Gate bit is ignored; class comes from pe_out / f_mem_w only
   logic w_unused_gate;
   assign w_unused_gate   = req0_i_jds[23] ^ req1_i_jds[23];
   assign w_gate0         = 1'b0;
   assign w_gate1         = 1'b0;
   assign w_run           = 1'b1;
   assign gate_done_o_jds = 1'b0;
`endif

   assign w_rem0 = ~w_gate0 & (req0_i_jds[22] | req0_i_jds[21]);
   assign w_rem1 = ~w_gate1 & (req1_i_jds[22] | req1_i_jds[21]);
   assign w_loc0 = ~w_gate0 & ~w_rem0;
   assign w_loc1 = ~w_gate1 & ~w_rem1;

   // Fullness uses the start-of-cycle count so the link ack never reaches rdy
   assign w_full   = (cnt_q == C_FULL);
   assign w_nempty = (cnt_q != '0);

   assign w_elig0 = vld0_i_jds & ~rst_i_jds & w_run & ~(w_rem0 & w_full);
   assign w_elig1 = vld1_i_jds & ~rst_i_jds & w_run & ~(w_rem1 & w_full);

   // prio names the requester that wins a tie
   assign w_gnt0 = w_elig0 & (~w_elig1 | ~prio_q);
   assign w_gnt1 = w_elig1 & (~w_elig0 |  prio_q);

   assign rdy0_o_jds = w_gnt0;
   assign rdy1_o_jds = w_gnt1;

   assign w_push     = (w_gnt0 & w_rem0) | (w_gnt1 & w_rem1);
   assign w_pop      = w_nempty & pkt_ack_i_jds;
   assign w_gnt_gate = (w_gnt0 & w_gate0) | (w_gnt1 & w_gate1);
   assign w_push_pkt = w_gnt1 ? {req1_i_jds[22], req1_i_jds[20:0]}
                              : {req0_i_jds[22], req0_i_jds[20:0]};

   // Next-state for pointers, occupancy, arbitration priority and PC load
   always_comb begin
      wr_d     = wr_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      prio_d   = prio_q;
      pc_ld_d  = 1'b0;
      pc_dst_d = pc_dst_q;
      if (w_push) wr_d = wr_q + AW'(1);
      if (w_pop)  rd_d = rd_q + AW'(1);
      case ({w_push, w_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      if (w_gnt0 | w_gnt1) prio_d = w_gnt0;
      if (w_gnt0 & w_loc0) begin
         pc_ld_d  = 1'b1;
         pc_dst_d = req0_i_jds[16:0];
      end else if (w_gnt1 & w_loc1) begin
         pc_ld_d  = 1'b1;
         pc_dst_d = req1_i_jds[16:0];
      end
   end

   // Control registers; reset flushes the FIFO and drops any pending packet
   always_ff @(posedge clk_i_jds) begin
      if (rst_i_jds) begin
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         prio_q   <= 1'b0;
         pc_ld_q  <= 1'b0;
         pc_dst_q <= '0;
      end else begin
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         prio_q   <= prio_d;
         pc_ld_q  <= pc_ld_d;
         pc_dst_q <= pc_dst_d;
      end
   end

   // FIFO payload storage; contents are don't-care while the slot is empty
   always_ff @(posedge clk_i_jds) begin
      if (w_push) fifo_q[wr_q] <= w_push_pkt;
   end

   assign pkt_req_o_jds = w_nempty;
   assign busy_o_jds    = w_nempty;
   assign pkt_o_jds     = w_nempty ? fifo_q[rd_q] : '0;
   assign pc_ld_o_jds   = pc_ld_q;
   assign pc_dst_o_jds  = pc_dst_q;

endmodule

`default_nettype wire

// File: doc/jmp_dispatch.md
# jmp_dispatch

Jump-result dispatcher between the two integer-unit Jump stages and the inter-PE packet link / local PC.
- Arbitrates round-robin between two jump requesters.
- Sends local jumps to the PC as a one-cycle load pulse.
- Queues remote-PE and memory-write packets in a FIFO and drains them over a req/ack link.
- Optionally implements the gate (drain barrier) instruction.

## Interface
Parameters:
- DEPTH, 4, remote-packet FIFO entries; power of two, ≥2.

Ports:
- clk_i_jds  in  1  clock.
- rst_i_jds  in  1  synchronous, active-high reset.
- vld0_i_jds, vld1_i_jds  in  1  requester 0/1 presents a jump result this cycle.
- req0_i_jds, req1_i_jds  in  24  packed {gate, f_mem_w, pe_out, pe_lr, pe_num[2:0], dst[16:0]}, bit 23 = gate.
- rdy0_o_jds, rdy1_o_jds  out  1  combinational grant; the request is consumed in any cycle where vld and rdy are both high.
- pkt_req_o_jds  out  1  packet valid to link.
- pkt_ack_i_jds  in  1  link accepts packet.
- pkt_o_jds  out  22  {f_mem_w, pe_lr, pe_num[2:0], dst[16:0]}.
- pc_ld_o_jds  out  1  local PC load pulse.
- pc_dst_o_jds  out  17  local jump target.
- gate_done_o_jds  out  1  gate barrier completed pulse.
- busy_o_jds  out  1  FIFO non-empty or pkt_req_o_jds high.

## Operation
Request classes:
- **Local:** pe_out=0, f_mem_w=0, gate=0.
- **Remote:** pe_out=1 or f_mem_w=1.
- **Gate:** gate=1. Only meaningful with JDS_GATE_EN.

Arbitration:
- At most one grant per cycle.
- prio register, reset 0. When both requesters are eligible, prio selects the winner.
- After any grant, prio is set to the non-granted index.

Eligibility:
- Any request is ineligible in GATE state.
- A remote request is ineligible when the FIFO is full. Fullness uses the start-of-cycle count; a same-cycle dequeue does not free a slot.
- Local requests are eligible regardless of FIFO level.

Local grant:
- pc_ld_o_jds=1 next cycle, for exactly one cycle.
- pc_dst_o_jds holds dst from the grant until the next local grant.

Remote grant:
- Writes {f_mem_w, pe_lr, pe_num, dst} to the FIFO tail.

Link side (always running, independent of arbitration):
- pkt_req_o_jds=1 whenever the FIFO is non-empty.
- pkt_o_jds = FIFO head. It is stable while pkt_req_o_jds=1 and ack is low.
- pkt_ack_i_jds sampled high with req high pops the head.
- If further entries exist, req stays high with the next entry presented the following cycle (back-to-back, no bubble).
- pkt_ack_i_jds while req is low is ignored.

Counter:
- count width is log2(DEPTH)+1.
- Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.

FSM: states RUN and GATE. Without JDS_GATE_EN the FSM is permanently RUN.

Reset (sync, mid-operation included):
- FIFO flushed; count=0; prio=0; state RUN.
- pkt_req_o_jds dropped even while unacknowledged; that packet is lost.
- Reset values:
  - pkt_req_o_jds=0, pc_ld_o_jds=0, gate_done_o_jds=0, busy_o_jds=0.
  - pc_dst_o_jds=0, pkt_o_jds=0.
  - rdy0_o_jds/rdy1_o_jds=0 during reset.

## Timing
- Remote request granted at cycle N into an empty FIFO: pkt_req_o_jds=1 at N+1.
- Local grant at N: pc_ld_o_jds at N+1.
- rdy*_o_jds depend combinationally on vld*, req class bits, count and state; no combinational path from pkt_ack_i_jds to rdy.
- Maximum throughput: one grant per cycle, one pop per cycle.

## Configuration
- JDS_GATE_EN defined:
  - A granted gate request moves the FSM to GATE at N+1.
  - In GATE, both rdy are 0.
  - The first cycle in GATE with count=0 transitions to RUN next cycle, with gate_done_o_jds=1 for that one cycle.
  - A gate grant with an empty FIFO gives gate_done_o_jds at N+2.
- JDS_GATE_EN undefined:
  - The gate bit is ignored; the request is classified by pe_out/f_mem_w.
  - gate_done_o_jds is tied 0 and the GATE state is absent.

## Test plan
- Local jump, vld0 with pe_out=0, dst=0x1ABCD at cycle 5 -> rdy0=1 at 5; pc_ld=1 and pc_dst=0x1ABCD at 6 only; pkt_req stays 0.
- Contention, both vld high with remote packets for 4 cycles from reset, ack tied 1 -> grants 0,1,0,1; pkt_o order matches grants; pkt_req from cycle 2 continuous.
- Full FIFO, DEPTH=4, ack=0, 5 remote requests -> 4 accepted, 5th rdy=0 until first ack; payload stable while ack low; busy=1 throughout.
- Link backpressure, ack toggling 1010 with 3 queued entries -> pops exactly on ack cycles; count never underflows; FIFO drains, then pkt_req=0 and busy=0.
- Reset mid-transfer, rst=1 with pkt_req=1 and 3 entries queued -> next cycle pkt_req=0, busy=0; after release, new request at N gives pkt_req at N+1 with new payload.
- Gate (JDS_GATE_EN), gate request with 2 entries queued, ack=1 -> rdy both 0; entries drain over 2 cycles; gate_done pulses once; next request accepted the cycle after.
